// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame states, protocol prefixes and player key codes for the PS/2 key decoder.
package ps2_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_st_t;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] CODE_IDLE = 8'h00;
  localparam logic [7:0] P1_DOWN   = 8'h72;
  localparam logic [7:0] P1_UP     = 8'h75;
  localparam logic [7:0] P1_RIGHT  = 8'h74;
  localparam logic [7:0] P1_LEFT   = 8'h6B;
  localparam logic [7:0] P2_DOWN   = 8'h1B;
  localparam logic [7:0] P2_UP     = 8'h1D;
  localparam logic [7:0] P2_RIGHT  = 8'h23;
  localparam logic [7:0] P2_LEFT   = 8'h1C;
  function automatic logic is_arrow(input logic [7:0] c);
    return c == P1_DOWN || c == P1_UP || c == P1_RIGHT || c == P1_LEFT;
  endfunction
endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: step-tick/scan-code bus between the key decoder (slave) and the game controller (master).
interface ps2_key_decoder_if;
  logic       key_en;
  logic [7:0] code_o;
  logic       held_o;
  logic       frame_err;
  modport master (output key_en, input code_o, held_o, frame_err);
  modport slave  (input key_en, output code_o, held_o, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises the raw PS/2 lines, detects falling clock edges and deframes
// 11-bit odd-parity frames, aborting a stalled frame via a watchdog.
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);
  import ps2_pkg::*;
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic [TO_W-1:0]        wd_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q, rx_byte_q;
  logic                   par_q, rx_valid_q, rx_err_q, fall, din, timeout;
  frame_st_t              state_q;
  assign fall    = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
  assign din     = data_sync_q[SYNC_STAGES-1];
  assign timeout = state_q != ST_IDLE && !fall && wd_q == TO_W'(TIMEOUT_CYCLES - 1);
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      wd_q        <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      wd_q        <= (state_q == ST_IDLE || fall) ? '0 : wd_q + 1'b1;
      if (timeout) begin
        state_q  <= ST_IDLE;
        rx_err_q <= 1'b1;
      end else if (fall) begin
        case (state_q)
          ST_IDLE: if (!din) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
          ST_DATA: begin
            shift_q   <= {din, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q   <= din;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            // odd parity: data bits plus parity bit must XOR to 1
            rx_valid_q <= din & (^{shift_q, par_q});
            rx_err_q   <= ~(din & (^{shift_q, par_q}));
            rx_byte_q  <= shift_q;
            state_q    <= ST_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: tracks PS/2 make/break state and presents the held key once per step tick.
// Define PS2_EXT_FILTER_EN to accept P1 codes only as E0-prefixed arrow keys.
module ps2_key_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input logic               clk,
  input logic               reset,
  input logic               ps2_clk,
  input logic               ps2_data,
  ps2_key_decoder_if.slave  bus
);
  import ps2_pkg::*;
  logic [7:0] rx_byte, held_code_q, held_code_d, code_q, code_d;
  logic       rx_valid, rx_err, held_q, held_d, brk_q, brk_d, ext_q, ext_d;
  logic       drop, data_ev, make_ev, brk_hit;
  ps2_rx_frame #(
    .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)
  ) u_rx (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err)
  );
`ifdef PS2_EXT_FILTER_EN
  assign drop = is_arrow(rx_byte) & ~ext_q;
`else
  assign drop = 1'b0;
`endif
  always_comb begin
    data_ev     = rx_valid && rx_byte != PS2_EXT && rx_byte != PS2_BRK;
    make_ev     = data_ev && !drop && !brk_q;
    brk_hit     = data_ev && !drop && brk_q && rx_byte == held_code_q;
    ext_d       = !rx_valid ? ext_q : rx_byte == PS2_EXT ? 1'b1 : rx_byte == PS2_BRK ? ext_q : 1'b0;
    brk_d       = !rx_valid ? brk_q : rx_byte == PS2_BRK ? 1'b1 : rx_byte == PS2_EXT ? brk_q : 1'b0;
    held_code_d = make_ev ? rx_byte : held_code_q;
    held_d      = make_ev ? 1'b1 : brk_hit ? 1'b0 : held_q;
    // a break landing on the tick suppresses it; a make waits for the next tick
    code_d      = (bus.key_en && held_q && !brk_hit) ? held_code_q : CODE_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_code_q <= CODE_IDLE;
      held_q      <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      code_q      <= CODE_IDLE;
    end else begin
      held_code_q <= held_code_d;
      held_q      <= held_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      code_q      <= code_d;
    end
  end
  assign bus.code_o    = code_q;
  assign bus.held_o    = held_q;
  assign bus.frame_err = rx_err;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: bit-bangs PS/2 frames into the decoder and checks it against a key-state model.
module tb_ps2_key_decoder;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  int tests = 0, fails = 0, err_cnt = 0;
  logic       m_held = 1'b0, m_brk = 1'b0, m_ext = 1'b0;
  logic [7:0] m_code = 8'h00;
  ps2_key_decoder_if bus();
  ps2_key_decoder dut (.clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.frame_err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clk(4);
      ps2_clk = 1'b0;
      wait_clk(4);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(8);
  endtask

  // Key state as the keyboard user sees it: prefixes arm flags, the next byte consumes them.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
`ifdef PS2_EXT_FILTER_EN
      if ((b == 8'h72 || b == 8'h75 || b == 8'h74 || b == 8'h6B) && !m_ext) begin
        m_brk = 1'b0;
        m_ext = 1'b0;
        return;
      end
`endif
      if (!m_brk) begin
        m_code = b;
        m_held = 1'b1;
      end else if (b == m_code) m_held = 1'b0;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
    send_bits(frame(b, bad_par, bad_stop), 11);
    if (!bad_par && !bad_stop) model_byte(b);
  endtask

  task automatic tick(input string tag);
    logic [7:0] exp;
    exp = m_held ? m_code : 8'h00;
    @(negedge clk) bus.key_en = 1'b1;
    @(negedge clk) bus.key_en = 1'b0;
    check({tag, "_code"}, bus.code_o, exp);
    check({tag, "_held"}, bus.held_o, m_held);
    @(negedge clk);
    check({tag, "_clr"}, bus.code_o, 8'h00);
  endtask

  initial begin
    int e0, n, kind;
    logic [7:0] b;
    logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h72, 8'h75, 8'h74, 8'h6B, 8'h1B, 8'h1D, 8'h23, 8'h1C};
    bus.key_en = 1'b0;
    wait_clk(3);
    check("rst_code", bus.code_o, 8'h00);
    check("rst_held", bus.held_o, 1'b0);
    check("rst_err", bus.frame_err, 1'b0);
    reset = 1'b0;
    wait_clk(4);
    e0 = err_cnt;
    send_bits(frame(8'hA5, 1'b0, 1'b0), 4);
    reset = 1'b1;
    wait_clk(3);
    check("midrst_code", bus.code_o, 8'h00);
    check("midrst_held", bus.held_o, 1'b0);
    reset = 1'b0;
    wait_clk(200);
    check("midrst_noerr", err_cnt - e0, 0);
    send(8'h1C);
    tick("after_rst");
    send(8'hE0);
    send(8'h75);
    for (int i = 0; i < 3; i++) tick("arrow_up");
    send(8'h1B);
    send(8'hF0);
    fork
      send_bits(frame(8'h1B, 1'b0, 1'b0), 11);
      begin
        n = 0;
        while (dut.rx_valid !== 1'b1 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        check("coinc_seen", n < 3000, 1);
        bus.key_en = 1'b1;
        @(negedge clk) bus.key_en = 1'b0;
        check("coinc_code", bus.code_o, 8'h00);
      end
    join
    model_byte(8'h1B);
    check("coinc_held", bus.held_o, 1'b0);
    send(8'h1D);
    e0 = err_cnt;
    send(8'h23, 1'b1);
    check("par_err", err_cnt - e0, 1);
    tick("par_keep");
    e0 = err_cnt;
    send_bits(frame(8'h74, 1'b0, 1'b0), 5);
    n = 0;
    while (err_cnt == e0 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    wait_clk(4);
    check("to_err", err_cnt - e0, 1);
    check("to_when", n >= 49950 && n <= 50050, 1);
    send(8'hE0);
    send(8'h74);
    tick("after_to");
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    send(8'h72);
    tick("kp2");
    for (int i = 0; i < 90; i++) begin
      kind = $urandom_range(0, 9);
      b = kind < 7 ? pool[$urandom_range(0, 9)] : 8'($urandom_range(1, 255));
      e0 = err_cnt;
      if (kind == 9) send(b, 1'b1, 1'b0);
      else if (kind == 8) send(b, 1'b0, 1'b1);
      else send(b);
      check("rnd_err", err_cnt - e0, kind >= 8 ? 1 : 0);
      if (i % 2 == 1) tick("rnd");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
